// File: rtl/inference_scheduler.sv
// Frame sequencer for the MNIST inference core: streams an image into the image RAM,
// pulses start, latches the predicted digit and guards against hung or stuck-DONE cores.
module inference_scheduler #(
   parameter int IMG_BYTES      = 784,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int DRAIN_MAX      = 16,
   parameter int CNT_W          = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   input  logic              run_req,
   input  logic              auto_run,
   output logic              img_we,
   output logic [ADDR_W-1:0] img_waddr,
   output logic [7:0]        img_wdata,
   output logic              inf_start,
   input  logic              inf_done,
   input  logic [3:0]        inf_digit,
   output logic              result_valid,
   output logic [3:0]        result_digit,
   output logic [7:0]        run_count,
   output logic              busy,
   output logic              timeout_err,
   output logic              stuck_err
);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_READY = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_BYTES - 1);
   localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
   localparam logic [CNT_W-1:0]  DRAIN_CAP  = CNT_W'(DRAIN_MAX);

   state_t            state_r;
   logic [ADDR_W-1:0] byte_cnt_r;
   logic [CNT_W-1:0]  wdog_r;

   assign ld_ready  = (state_r == S_LOAD);
   assign img_we    = ld_valid & ld_ready;
   assign img_waddr = byte_cnt_r;
   assign img_wdata = ld_data;

   // busy covers the whole core handshake, from the start pulse until done has cleared
   always_comb begin
      busy = 1'b0;
      case (state_r)
         S_START, S_RUN, S_DRAIN: busy = 1'b1;
         default:                 busy = 1'b0;
      endcase
   end

   // frame sequencing, watchdog and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_LOAD;
         byte_cnt_r   <= '0;
         wdog_r       <= '0;
         inf_start    <= 1'b0;
         result_valid <= 1'b0;
         result_digit <= 4'd0;
         run_count    <= 8'd0;
         timeout_err  <= 1'b0;
         stuck_err    <= 1'b0;
      end else begin
         inf_start    <= 1'b0;
         result_valid <= 1'b0;
         case (state_r)
            S_LOAD: begin
               if (img_we) begin
                  if (byte_cnt_r == LAST_ADDR) begin
                     byte_cnt_r <= '0;
                     state_r    <= S_READY;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + ADDR_W'(1);
                  end
               end
            end
            S_READY: begin
               // run_req outside this state is simply dropped
               if (auto_run || run_req) begin
                  inf_start <= 1'b1;
                  state_r   <= S_START;
               end
            end
            S_START: begin
               wdog_r  <= '0;
               state_r <= S_RUN;
            end
            S_RUN: begin
               if (inf_done) begin
                  result_digit <= inf_digit;
                  result_valid <= 1'b1;
                  run_count    <= run_count + 8'd1;
                  wdog_r       <= '0;
                  state_r      <= S_DRAIN;
               end else if (wdog_r == RUN_LAST) begin
                  timeout_err <= 1'b1;
                  wdog_r      <= '0;
                  state_r     <= S_DRAIN;
               end else begin
                  wdog_r <= wdog_r + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (!inf_done) begin
                  wdog_r  <= '0;
                  state_r <= S_LOAD;
               end else begin
                  // saturate so a core parked in DONE cannot wrap the counter
                  if (wdog_r != DRAIN_CAP) begin
                     wdog_r <= wdog_r + CNT_W'(1);
                  end
                  if (wdog_r == DRAIN_LAST) begin
                     stuck_err <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed/randomized bench for inference_scheduler: the bench plays loader and core,
// and keeps its own record of expected image contents, runs, digits and error flags.
module tb_inference_scheduler;

   localparam int IMG = 784;
   localparam int TO  = 100;
   localparam int DM  = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'd0;
   logic       ld_ready;
   logic       run_req = 1'b0;
   logic       auto_run = 1'b0;
   logic       img_we;
   logic [9:0] img_waddr;
   logic [7:0] img_wdata;
   logic       inf_start;
   logic       inf_done = 1'b0;
   logic [3:0] inf_digit = 4'd0;
   logic       result_valid;
   logic [3:0] result_digit;
   logic [7:0] run_count;
   logic       busy;
   logic       timeout_err;
   logic       stuck_err;

   inference_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .run_req(run_req), .auto_run(auto_run), .img_we(img_we), .img_waddr(img_waddr),
      .img_wdata(img_wdata), .inf_start(inf_start), .inf_done(inf_done),
      .inf_digit(inf_digit), .result_valid(result_valid), .result_digit(result_digit),
      .run_count(run_count), .busy(busy), .timeout_err(timeout_err), .stuck_err(stuck_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // expected model
   logic [7:0] img_exp [IMG];
   int         m_runs = 0;
   int         m_starts = 0;
   int         m_rv = 0;
   logic [3:0] m_digit = 4'd0;
   logic       m_terr = 1'b0;
   logic       m_serr = 1'b0;

   // observation of the RAM write port and pulse outputs
   logic [7:0] wmem [IMG];
   int wr_cnt = 0;
   int addr_bad = 0;
   int exp_addr = 0;
   int start_cnt = 0;
   int rv_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_addr <= 0;
      end else begin
         if (img_we) begin
            if (int'(img_waddr) < IMG) wmem[img_waddr] <= img_wdata;
            if (int'(img_waddr) != exp_addr) addr_bad <= addr_bad + 1;
            wr_cnt   <= wr_cnt + 1;
            exp_addr <= (exp_addr + 1) % IMG;
         end
         if (inf_start)    start_cnt <= start_cnt + 1;
         if (result_valid) rv_cnt    <= rv_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_digit"},   32'(result_digit), 32'(m_digit));
      check({tag, "_runs"},    32'(run_count),    32'(m_runs % 256));
      check({tag, "_timeout"}, 32'(timeout_err),  32'(m_terr));
      check({tag, "_stuck"},   32'(stuck_err),    32'(m_serr));
      check({tag, "_rvcount"}, 32'(rv_cnt),       32'(m_rv));
      check({tag, "_starts"},  32'(start_cnt),    32'(m_starts));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_digit"},   32'(result_digit), 32'd0);
      check({tag, "_runs"},    32'(run_count),    32'd0);
      check({tag, "_rv"},      32'(result_valid), 32'd0);
      check({tag, "_start"},   32'(inf_start),    32'd0);
      check({tag, "_errs"},    32'({timeout_err, stuck_err}), 32'd0);
      check({tag, "_busy"},    32'(busy),         32'd0);
      check({tag, "_ldready"}, 32'(ld_ready),     32'd1);
      check({tag, "_waddr"},   32'(img_waddr),    32'd0);
      check({tag, "_we"},      32'(img_we),       32'(ld_valid));
      m_runs = 0; m_digit = 4'd0; m_terr = 1'b0; m_serr = 1'b0;
      inf_done = 1'b0; run_req = 1'b0; ld_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // stream a full image with random bubbles; ends at the cycle after the last accept
   task automatic load_image(input bit pat_addr, input bit noise_req);
      int i = 0;
      int budget = 0;
      int w0 = wr_cnt;
      int bad = 0;
      check("load_ldready", 32'(ld_ready), 32'd1);
      while (i < IMG && budget < 4000) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = pat_addr ? i[7:0] : 8'($urandom);
         run_req  = noise_req ? 1'($urandom_range(0, 1)) : 1'b0;
         if (ld_valid) img_exp[i] = ld_data;
         tick();
         if (ld_valid) i++;
         budget++;
      end
      ld_valid = 1'b0;
      run_req  = 1'b0;
      check("load_complete", 32'(i), 32'(IMG));
      for (int a = 0; a < IMG; a++) if (wmem[a] !== img_exp[a]) bad++;
      check("img_contents", 32'(bad), 32'd0);
      check("img_writes", 32'(wr_cnt - w0), 32'(IMG));
      check("img_addr_order", 32'(addr_bad), 32'd0);
      check("ready_ldready", 32'(ld_ready), 32'd0);
      check("ready_start", 32'(inf_start), 32'd0);
      check("ready_busy", 32'(busy), 32'd0);
   endtask

   task automatic start_run(input bit manual);
      if (manual) begin
         int idle = $urandom_range(3, 8);
         for (int k = 0; k < idle; k++) begin
            ld_valid = 1'b1;
            tick();
            check("hold_ready_start", 32'(inf_start), 32'd0);
            check("hold_ready_we", 32'(img_we), 32'd0);
            check("hold_ready_busy", 32'(busy), 32'd0);
         end
         ld_valid = 1'b0;
         run_req  = 1'b1;
         tick();
         run_req  = 1'b0;
      end else begin
         tick();
      end
      m_starts++;
      check("start_pulse", 32'(inf_start), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
   endtask

   // core answers after lat idle run cycles and holds done for hold cycles
   task automatic core_frame(input logic [3:0] digit, input int lat, input int hold, input bit noise);
      tick();
      check("start_one_cycle", 32'(inf_start), 32'd0);
      for (int k = 0; k < lat; k++) begin
         run_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         check("run_no_result", 32'(result_valid), 32'd0);
      end
      run_req   = 1'b0;
      inf_done  = 1'b1;
      inf_digit = digit;
      tick();
      m_runs++; m_digit = digit; m_rv++;
      check("done_rv", 32'(result_valid), 32'd1);
      check("done_digit", 32'(result_digit), 32'(digit));
      check("done_runs", 32'(run_count), 32'(m_runs % 256));
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_ldready", 32'(ld_ready), 32'd0);
      for (int h = 1; h < hold; h++) begin
         inf_digit = 4'($urandom);
         tick();
         if (h >= DM) m_serr = 1'b1;
         check("drain_hold_ldready", 32'(ld_ready), 32'd0);
         check("stuck_flag", 32'(stuck_err), 32'(m_serr));
      end
      inf_done = 1'b0;
      tick();
      check("reload_ldready", 32'(ld_ready), 32'd1);
      check("reload_busy", 32'(busy), 32'd0);
      check("rv_one_shot", 32'(result_valid), 32'd0);
      check_model("frame");
   endtask

   task automatic timeout_frame();
      tick();
      for (int c = 1; c < TO; c++) begin
         tick();
         check("to_busy", 32'(busy), 32'd1);
      end
      check("to_not_yet", 32'(timeout_err), 32'd0);
      tick();
      m_terr = 1'b1;
      check("to_flag", 32'(timeout_err), 32'd1);
      check("to_drain_ldready", 32'(ld_ready), 32'd0);
      tick();
      check("to_reload_ldready", 32'(ld_ready), 32'd1);
      check_model("timeout");
   endtask

   initial begin
      // reset values and combinational write enable
      do_reset("reset");
      ld_valid = 1'b1;
      #1;
      check("comb_we_hi", 32'(img_we), 32'd1);
      check("comb_waddr", 32'(img_waddr), 32'd0);
      ld_valid = 1'b0;
      #1;
      check("comb_we_lo", 32'(img_we), 32'd0);

      // load (value = address) and auto run, digit 7
      auto_run = 1'b1;
      load_image(1'b1, 1'b0);
      start_run(1'b0);
      core_frame(4'd7, $urandom_range(3, 20), 3, 1'b0);

      // retrigger: two back-to-back frames, digits 3 and 9
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd3, $urandom_range(1, 30), $urandom_range(2, 6), 1'b0);
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd9, $urandom_range(1, 30), $urandom_range(2, 6), 1'b0);

      // done arriving on the final watchdog cycle wins over the timeout
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd5, TO - 1, 1, 1'b0);

      // manual start with run_req noise during load and run
      auto_run = 1'b0;
      load_image(1'b0, 1'b1);
      start_run(1'b1);
      core_frame(4'd2, $urandom_range(5, 40), 2, 1'b1);

      // hung core
      auto_run = 1'b1;
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      timeout_frame();

      // core parked in DONE for 40 cycles
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd4, 5, 40, 1'b0);

      // reset in the middle of a load
      for (int b = 0; b < 400; b++) begin
         ld_valid = 1'b1;
         ld_data  = 8'($urandom);
         tick();
      end
      check("midload_addr", 32'(img_waddr), 32'd400);
      do_reset("midload_rst");
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd6, $urandom_range(1, 20), 2, 1'b0);

      // reset while the core is running
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      tick(); tick(); tick();
      check("midrun_busy", 32'(busy), 32'd1);
      do_reset("midrun_rst");
      load_image(1'b0, 1'b0);
      start_run(1'b0);
      core_frame(4'd8, $urandom_range(1, 20), 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
